// File: rtl/video_timing_rx.sv
// Video timing receiver: measures active width/height from DE/VS, tracks format
// lock over consecutive good frames, and captures one probe pixel per frame.
module video_timing_rx #(
  parameter int unsigned X_BITS      = 13,
  parameter int unsigned Y_BITS      = 13,
  parameter logic [11:0] H_ACT       = 12'd1920,
  parameter logic [11:0] V_ACT       = 12'd1080,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic              pix_clk,
  input  logic              rstn,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [15:0]       rgb_in,
  input  logic [X_BITS-1:0] probe_x,
  input  logic [Y_BITS-1:0] probe_y,
  output logic [X_BITS-1:0] act_x,
  output logic [Y_BITS-1:0] act_y,
  output logic              pix_valid,
  output logic [15:0]       pix_data,
  output logic [X_BITS-1:0] h_meas,
  output logic [Y_BITS-1:0] v_meas,
  output logic [15:0]       probe_data,
  output logic              probe_valid,
  output logic              frame_done,
  output logic              locked,
  output logic              fmt_err
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SEARCH   = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [X_BITS-1:0] H_ACT_X = X_BITS'(H_ACT);
  localparam logic [Y_BITS-1:0] V_ACT_Y = Y_BITS'(V_ACT);
  localparam logic [7:0]        LOCK_N  = 8'(LOCK_FRAMES);

  state_t            r_state, w_stateNext;
  logic [7:0]        r_goodCnt, w_goodNext;
  logic              w_fmtErrNext;

  logic              r_vsPrev, r_hsPrev, r_dePrev;
  logic              w_vsRise, w_deFall, w_hsRise, w_hsFall, w_unusedHsEdges;

  logic [X_BITS-1:0] r_colCnt, r_firstW, r_probeX, w_colInc;
  logic [Y_BITS-1:0] r_rowCnt, r_probeY, w_rowInc, w_rowFinal;
  logic              r_lineErr, r_widthBad, r_skipLine, r_armed;
  logic              w_lineDone, w_lineMismatch, w_widthMismatch;
  logic              w_good, w_eval, w_overflow, w_probeHit;

  assign w_vsRise        = vs_in & ~r_vsPrev;
  assign w_deFall        = ~de_in & r_dePrev;
  assign w_hsRise        = hs_in & ~r_hsPrev;
  assign w_hsFall        = ~hs_in & r_hsPrev;
  assign w_unusedHsEdges = w_hsRise | w_hsFall;

  // A line cut short by VS is flagged in r_skipLine and never measured.
  assign w_lineDone      = w_deFall & ~r_skipLine;
  assign w_colInc        = (&r_colCnt) ? r_colCnt : r_colCnt + X_BITS'(1);
  assign w_rowInc        = (&r_rowCnt) ? r_rowCnt : r_rowCnt + Y_BITS'(1);
  assign w_rowFinal      = w_lineDone ? w_rowInc : r_rowCnt;
  assign w_lineMismatch  = w_lineDone & (r_rowCnt != '0) & (r_colCnt != r_firstW);
  assign w_widthMismatch = w_lineDone & (r_colCnt != H_ACT_X);
  assign w_good          = (w_rowFinal == V_ACT_Y) & ~(r_lineErr | w_lineMismatch)
                         & ~(r_widthBad | w_widthMismatch);
  assign w_eval          = w_vsRise & r_armed;
  assign w_overflow      = (r_state == LOCKED) & de_in & ~r_skipLine & ~w_vsRise
                         & (r_colCnt == H_ACT_X);
  assign w_probeHit      = r_armed & de_in & ~r_skipLine & ~w_vsRise
                         & (r_colCnt == r_probeX) & (r_rowCnt == r_probeY)
                         & (r_probeX < H_ACT_X) & (r_probeY < V_ACT_Y);

  assign locked = (r_state == LOCKED);

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      r_vsPrev <= 1'b0;
      r_hsPrev <= 1'b0;
      r_dePrev <= 1'b0;
    end else begin
      r_vsPrev <= vs_in;
      r_hsPrev <= hs_in;
      r_dePrev <= de_in;
    end
  end

  // A line ending on the VS edge is folded into the frame before v_meas latches.
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      r_colCnt   <= '0;
      r_rowCnt   <= '0;
      r_firstW   <= '0;
      r_probeX   <= '0;
      r_probeY   <= '0;
      r_lineErr  <= 1'b0;
      r_widthBad <= 1'b0;
      r_skipLine <= 1'b0;
      r_armed    <= 1'b0;
      h_meas     <= '0;
      v_meas     <= '0;
    end else if (w_vsRise) begin
      if (w_lineDone) h_meas <= r_colCnt;
      v_meas     <= w_rowFinal;
      r_colCnt   <= '0;
      r_rowCnt   <= '0;
      r_firstW   <= '0;
      r_lineErr  <= 1'b0;
      r_widthBad <= 1'b0;
      r_skipLine <= de_in;
      r_armed    <= 1'b1;
      r_probeX   <= probe_x;
      r_probeY   <= probe_y;
    end else if (w_lineDone) begin
      h_meas   <= r_colCnt;
      r_rowCnt <= w_rowInc;
      r_colCnt <= '0;
      if (r_rowCnt == '0) r_firstW <= r_colCnt;
      if (w_lineMismatch) r_lineErr <= 1'b1;
      if (w_widthMismatch) r_widthBad <= 1'b1;
    end else if (w_deFall) begin
      r_skipLine <= 1'b0;
      r_colCnt   <= '0;
    end else if (de_in && !r_skipLine) begin
      r_colCnt <= w_colInc;
    end
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      act_x       <= '0;
      act_y       <= '0;
      probe_valid <= 1'b0;
      probe_data  <= '0;
      frame_done  <= 1'b0;
      fmt_err     <= 1'b0;
    end else begin
      pix_valid   <= de_in;
      pix_data    <= rgb_in;
      if (de_in) begin
        act_x <= r_colCnt;
        act_y <= r_rowCnt;
      end
      probe_valid <= w_probeHit;
      if (w_probeHit) probe_data <= rgb_in;
      frame_done  <= w_vsRise;
      fmt_err     <= w_fmtErrNext;
    end
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= UNLOCKED;
      r_goodCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_goodCnt <= w_goodNext;
    end
  end

  // Frames are judged only at VS edges; an overlong line while locked drops lock at once.
  always_comb begin
    w_stateNext  = r_state;
    w_goodNext   = r_goodCnt;
    w_fmtErrNext = 1'b0;
    if (w_eval) begin
      unique case (r_state)
        UNLOCKED: begin
          if (w_good) begin
            w_goodNext  = 8'd1;
            w_stateNext = (LOCK_N <= 8'd1) ? LOCKED : SEARCH;
          end
        end
        SEARCH: begin
          if (w_good) begin
            w_goodNext = r_goodCnt + 8'd1;
            if (w_goodNext >= LOCK_N) w_stateNext = LOCKED;
          end else begin
            w_goodNext  = '0;
            w_stateNext = UNLOCKED;
          end
        end
        LOCKED: begin
          if (!w_good) begin
            w_goodNext   = '0;
            w_stateNext  = UNLOCKED;
            w_fmtErrNext = 1'b1;
          end
        end
        default: begin
          w_goodNext  = '0;
          w_stateNext = UNLOCKED;
        end
      endcase
    end else if (w_overflow) begin
      w_goodNext   = '0;
      w_stateNext  = UNLOCKED;
      w_fmtErrNext = 1'b1;
    end
  end

endmodule
